// File: rtl/ddr3_ui_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ui_pkg
// Purpose  : Shared definitions for the DDR3 MIG user-interface responder:
//            app command encodings, burst beat count, FSM state types and a
//            command legality helper.
// Revision : 1.0 - initial release
// ============================================================================
package ddr3_ui_pkg;

    localparam logic [2:0] CMD_WR      = 3'b000;
    localparam logic [2:0] CMD_RD      = 3'b001;
    localparam int         BURST_BEATS = 2;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } top_state_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BEAT0 = 2'd2,
        RD_BEAT1 = 2'd3
    } rd_state_t;

    function automatic logic cmd_is_legal(input logic [2:0] cmd);
        return (cmd == CMD_WR) || (cmd == CMD_RD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_ui_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ui_sync_fifo
// Purpose  : Single-clock FIFO with show-ahead output (data_o is the head
//            entry whenever empty_o is low).
// Ports    : clk, rst (async, active high)
//            push_i/data_i  - write side, ignored when full
//            pop_i          - consume head, ignored when empty
//            data_o         - head entry
//            full_o/empty_o/count_o - occupancy
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_ui_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/ddr3_ui_responder.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ui_responder
// Purpose  : Memory-side stand-in for a DDR3 MIG user interface. Accepts app
//            commands and write beats, stores BL8 bursts (two 32-bit beats)
//            in block RAM and returns read bursts after a fixed latency.
// Ports    : ui_clk, rst (async, active high)
//            o_app_phy_init_done      - high once the init delay has elapsed
//            i_app_en/cmd/addr, o_app_rdy           - command channel
//            i_app_wdf_wren/end/data, o_app_wdf_rdy - write data channel
//            o_app_rd_data_valid/end/data           - read data channel
//            i_stall                  - forces both ready outputs low
//            o_fault                  - sticky illegal-command/framing flag
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_ui_responder
    import ddr3_ui_pkg::*;
#(
    parameter int MEM_ADDR_DEPTH = 28,
    parameter int STORE_DEPTH    = 10,
    parameter int CMD_FIFO_DEPTH = 3,
    parameter int WDF_FIFO_DEPTH = 4,
    parameter int INIT_CLKS      = 200,
    parameter int RD_LATENCY     = 8
) (
    input  logic                      ui_clk,
    input  logic                      rst,
    output logic                      o_app_phy_init_done,
    output logic                      o_app_rdy,
    output logic                      o_app_wdf_rdy,
    input  logic                      i_app_en,
    input  logic [2:0]                i_app_cmd,
    input  logic [MEM_ADDR_DEPTH-1:0] i_app_addr,
    input  logic                      i_app_wdf_wren,
    input  logic                      i_app_wdf_end,
    input  logic [31:0]               i_app_wdf_data,
    output logic                      o_app_rd_data_valid,
    output logic                      o_app_rd_data_end,
    output logic [31:0]               o_app_rd_data,
    input  logic                      i_stall,
    output logic                      o_fault
);

    localparam int CMD_W   = 1 + STORE_DEPTH;   // {is_read, burst index}
    localparam int INIT_CW = $clog2(INIT_CLKS + 1);
    localparam int LAT_CW  = $clog2(RD_LATENCY + 1);
    localparam logic [INIT_CW-1:0]      INIT_LAST = INIT_CW'(INIT_CLKS - 1);
    localparam logic [LAT_CW-1:0]       LAT_LAST  = LAT_CW'(RD_LATENCY - 1);
    localparam logic [WDF_FIFO_DEPTH:0] WDF_BURST = (WDF_FIFO_DEPTH + 1)'(BURST_BEATS);

    // ---------------------------------------------------------------- init
    top_state_t         state_q;
    logic [INIT_CW-1:0] init_cnt_q;
    logic               init_done_q;

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                ST_RUN:  init_done_q <= 1'b1;
                default: state_q     <= ST_INIT;
            endcase
        end
    end

    assign o_app_phy_init_done = init_done_q;

    // ------------------------------------------------------------- queues
    logic                      cmd_full, cmd_empty, cmd_pop, cmd_push;
    logic [CMD_W-1:0]          cmd_din, cmd_dout;
    logic [CMD_FIFO_DEPTH:0]   unused_cmd_count;
    logic                      wdf_full, wdf_empty, wdf_pop, wdf_push;
    logic [31:0]               wdf_dout;
    logic [WDF_FIFO_DEPTH:0]   wdf_count;
    logic                      cmd_accept;
    logic                      unused_wdf_empty;
    logic                      unused_addr_bits;

    assign o_app_rdy     = (state_q == ST_RUN) & ~cmd_full & ~i_stall;
    assign o_app_wdf_rdy = (state_q == ST_RUN) & ~wdf_full & ~i_stall;

    assign cmd_accept = i_app_en & o_app_rdy;
    assign cmd_push   = cmd_accept & cmd_is_legal(i_app_cmd);
    // Only the read/write distinction and the stored burst index matter
    // downstream; upper address bits alias onto the same burst.
    assign cmd_din    = {(i_app_cmd == CMD_RD), i_app_addr[STORE_DEPTH+2:3]};
    assign wdf_push   = i_app_wdf_wren & o_app_wdf_rdy;

    assign unused_wdf_empty = wdf_empty;
    assign unused_addr_bits = ^i_app_addr;

    ddr3_ui_sync_fifo #(
        .WIDTH      (CMD_W),
        .DEPTH_LOG2 (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (ui_clk),
        .rst     (rst),
        .push_i  (cmd_push),
        .data_i  (cmd_din),
        .pop_i   (cmd_pop),
        .data_o  (cmd_dout),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (unused_cmd_count)
    );

    ddr3_ui_sync_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (WDF_FIFO_DEPTH)
    ) u_wdf_fifo (
        .clk     (ui_clk),
        .rst     (rst),
        .push_i  (wdf_push),
        .data_i  (i_app_wdf_data),
        .pop_i   (wdf_pop),
        .data_o  (wdf_dout),
        .full_o  (wdf_full),
        .empty_o (wdf_empty),
        .count_o (wdf_count)
    );

    // ------------------------------------------------------ fault tracking
    logic fault_q;
    logic expect_end_q;

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            fault_q      <= 1'b0;
            expect_end_q <= 1'b0;
        end else begin
            if (cmd_accept && !cmd_is_legal(i_app_cmd)) fault_q <= 1'b1;
            if (wdf_push) begin
                if (i_app_wdf_end != expect_end_q) fault_q <= 1'b1;
                // Resynchronise on the beat just seen so one bad beat
                // does not cascade into a stream of framing errors.
                expect_end_q <= ~i_app_wdf_end;
            end
        end
    end

    assign o_fault = fault_q;

    // ----------------------------------------------------------- dispatch
    rd_state_t              rd_state_q;
    logic [STORE_DEPTH-1:0] rd_idx_q;
    logic [LAT_CW-1:0]      lat_cnt_q;
    logic                   rd_valid_q, rd_end_q;
    logic                   wr_phase_q, wr_phase_d;
    logic                   rd_start;
    logic                   ram_we, ram_re;
    logic [STORE_DEPTH:0]   ram_waddr, ram_raddr;
    logic                   head_rd;
    logic [STORE_DEPTH-1:0] head_idx;
    logic                   rd_conflict;

    assign head_rd  = cmd_dout[CMD_W-1];
    assign head_idx = cmd_dout[STORE_DEPTH-1:0];
    // A write must not overtake an in-flight read of the same burst: the
    // read engine still samples RAM during WAIT's last cycle and BEAT0.
    assign rd_conflict = (rd_state_q == RD_WAIT || rd_state_q == RD_BEAT0) &&
                         (rd_idx_q == head_idx);

    always_comb begin
        cmd_pop    = 1'b0;
        wdf_pop    = 1'b0;
        ram_we     = 1'b0;
        rd_start   = 1'b0;
        wr_phase_d = wr_phase_q;
        ram_waddr  = {head_idx, wr_phase_q};
        if (!cmd_empty) begin
            if (!head_rd) begin
                if (wr_phase_q) begin
                    wdf_pop    = 1'b1;
                    ram_we     = 1'b1;
                    cmd_pop    = 1'b1;
                    wr_phase_d = 1'b0;
                end else if (wdf_count >= WDF_BURST && !rd_conflict) begin
                    wdf_pop    = 1'b1;
                    ram_we     = 1'b1;
                    wr_phase_d = 1'b1;
                end
            end else if (rd_state_q == RD_IDLE) begin
                cmd_pop  = 1'b1;
                rd_start = 1'b1;
            end
        end
    end

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) wr_phase_q <= 1'b0;
        else     wr_phase_q <= wr_phase_d;
    end

    // --------------------------------------------------------- read engine
    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            rd_idx_q   <= '0;
            lat_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_end_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_start) begin
                        rd_idx_q   <= head_idx;
                        lat_cnt_q  <= '0;
                        rd_state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        rd_state_q <= RD_BEAT0;
                        rd_valid_q <= 1'b1;
                        rd_end_q   <= 1'b0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                RD_BEAT0: begin
                    rd_state_q <= RD_BEAT1;
                    rd_end_q   <= 1'b1;
                end
                RD_BEAT1: begin
                    rd_state_q <= RD_IDLE;
                    rd_valid_q <= 1'b0;
                    rd_end_q   <= 1'b0;
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // RAM read is issued on the edge that enters each beat state, so the
    // registered RAM output is the beat data.
    assign ram_re    = ((rd_state_q == RD_WAIT) && (lat_cnt_q == LAT_LAST)) ||
                       (rd_state_q == RD_BEAT0);
    assign ram_raddr = {rd_idx_q, (rd_state_q == RD_BEAT0)};

    // ----------------------------------------------------------- burst RAM
    logic [31:0] mem_q [2**(STORE_DEPTH+1)];
    logic [31:0] ram_rdata_q;

    always_ff @(posedge ui_clk) begin
        if (ram_we) mem_q[ram_waddr] <= wdf_dout;
        if (ram_re) ram_rdata_q      <= mem_q[ram_raddr];
    end

    assign o_app_rd_data_valid = rd_valid_q;
    assign o_app_rd_data_end   = rd_end_q;
    // RAM output has no reset; gating with valid keeps the bus at zero
    // outside a burst and through reset.
    assign o_app_rd_data       = ram_rdata_q & {32{rd_valid_q}};

endmodule
`default_nettype wire

// File: tb/tb_ddr3_ui_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_ui_responder
// Purpose  : Self-checking bench for ddr3_ui_responder. A behavioural model
//            keeps command/data queues and a burst memory; read bursts are
//            predicted in command order and compared by a read monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_ui_responder;
    import ddr3_ui_pkg::*;

    localparam int MAD  = 28;
    localparam int SD   = 10;
    localparam int INIT = 200;
    localparam int LAT  = 8;

    logic            ui_clk = 1'b0;
    logic            rst;
    logic            o_app_phy_init_done, o_app_rdy, o_app_wdf_rdy;
    logic            i_app_en;
    logic [2:0]      i_app_cmd;
    logic [MAD-1:0]  i_app_addr;
    logic            i_app_wdf_wren, i_app_wdf_end;
    logic [31:0]     i_app_wdf_data;
    logic            o_app_rd_data_valid, o_app_rd_data_end;
    logic [31:0]     o_app_rd_data;
    logic            i_stall;
    logic            o_fault;

    ddr3_ui_responder #(
        .MEM_ADDR_DEPTH (MAD),
        .STORE_DEPTH    (SD),
        .CMD_FIFO_DEPTH (3),
        .WDF_FIFO_DEPTH (4),
        .INIT_CLKS      (INIT),
        .RD_LATENCY     (LAT)
    ) dut (
        .ui_clk              (ui_clk),
        .rst                 (rst),
        .o_app_phy_init_done (o_app_phy_init_done),
        .o_app_rdy           (o_app_rdy),
        .o_app_wdf_rdy       (o_app_wdf_rdy),
        .i_app_en            (i_app_en),
        .i_app_cmd           (i_app_cmd),
        .i_app_addr          (i_app_addr),
        .i_app_wdf_wren      (i_app_wdf_wren),
        .i_app_wdf_end       (i_app_wdf_end),
        .i_app_wdf_data      (i_app_wdf_data),
        .o_app_rd_data_valid (o_app_rd_data_valid),
        .o_app_rd_data_end   (o_app_rd_data_end),
        .o_app_rd_data       (o_app_rd_data),
        .i_stall             (i_stall),
        .o_fault             (o_fault)
    );

    always #5 ui_clk = ~ui_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------- model
    typedef struct {
        bit rd;
        int idx;
    } mcmd_t;

    mcmd_t        mcmd [$];
    logic [31:0]  mdata[$];
    logic [32:0]  expq [$];   // {end, data}
    logic [31:0]  mmem [int]; // keyed by burst*2 + beat
    bit           exp_fault = 1'b0;
    bit           exp_end   = 1'b0;

    function automatic int idx_of(input logic [MAD-1:0] a);
        return (int'(a) / 8) % (1 << SD);
    endfunction

    // Execute queued commands in order as far as available data allows.
    function automatic void resolve();
        while (mcmd.size() > 0) begin
            if (!mcmd[0].rd) begin
                if (mdata.size() < 2) break;
                mmem[mcmd[0].idx * 2]     = mdata.pop_front();
                mmem[mcmd[0].idx * 2 + 1] = mdata.pop_front();
            end else begin
                expq.push_back({1'b0, mmem[mcmd[0].idx * 2]});
                expq.push_back({1'b1, mmem[mcmd[0].idx * 2 + 1]});
            end
            void'(mcmd.pop_front());
        end
    endfunction

    function automatic void model_cmd(input logic [2:0] c, input logic [MAD-1:0] a);
        mcmd_t m;
        if (c == CMD_WR || c == CMD_RD) begin
            m.rd  = (c == CMD_RD);
            m.idx = idx_of(a);
            mcmd.push_back(m);
            resolve();
        end else begin
            exp_fault = 1'b1;
        end
    endfunction

    function automatic void model_beat(input logic e, input logic [31:0] d);
        if (e != exp_end) exp_fault = 1'b1;
        exp_end = ~e;
        mdata.push_back(d);
        resolve();
    endfunction

    // ----------------------------------------------------------- monitor
    always @(negedge ui_clk) begin
        logic [32:0] e;
        if (o_app_rd_data_valid === 1'b1) begin
            if (expq.size() == 0) begin
                chk("rd_unexpected_beat", 64'(expq.size()), 64'd1);
            end else begin
                e = expq.pop_front();
                chk("rd_data", 64'(o_app_rd_data), 64'(e[31:0]));
                chk("rd_end", 64'(o_app_rd_data_end), 64'(e[32]));
            end
        end
    end

    // ------------------------------------------------------------- tasks
    task automatic send_cmd(input logic [2:0] c, input logic [MAD-1:0] a);
        int n = 0;
        @(negedge ui_clk);
        i_app_en = 1'b1; i_app_cmd = c; i_app_addr = a;
        #1;
        while (!o_app_rdy && n < 500) begin
            @(negedge ui_clk); #1; n++;
        end
        if (!o_app_rdy) begin
            chk("cmd_rdy_timeout", 64'(o_app_rdy), 64'd1);
        end else begin
            @(posedge ui_clk);
            model_cmd(c, a);
        end
        #1 i_app_en = 1'b0;
    endtask

    task automatic send_beat(input logic e, input logic [31:0] d);
        int n = 0;
        @(negedge ui_clk);
        i_app_wdf_wren = 1'b1; i_app_wdf_end = e; i_app_wdf_data = d;
        #1;
        while (!o_app_wdf_rdy && n < 500) begin
            @(negedge ui_clk); #1; n++;
        end
        if (!o_app_wdf_rdy) begin
            chk("wdf_rdy_timeout", 64'(o_app_wdf_rdy), 64'd1);
        end else begin
            @(posedge ui_clk);
            model_beat(e, d);
        end
        #1 i_app_wdf_wren = 1'b0;
    endtask

    task automatic write_burst(input logic [MAD-1:0] a, input logic [31:0] d0,
                               input logic [31:0] d1, input bit data_first);
        if (data_first) begin
            send_beat(1'b0, d0); send_beat(1'b1, d1); send_cmd(CMD_WR, a);
        end else begin
            send_cmd(CMD_WR, a); send_beat(1'b0, d0); send_beat(1'b1, d1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() > 0 && n < 3000) begin
            @(negedge ui_clk); n++;
        end
        repeat (4) @(negedge ui_clk);
        chk("drain", 64'(expq.size()), 64'd0);
    endtask

    // Called with rst high; releases it and checks the init delay.
    task automatic init_seq();
        @(negedge ui_clk);
        rst = 1'b0;
        for (int k = 1; k <= INIT; k++) begin
            @(negedge ui_clk);
            if (k == INIT - 1) begin
                chk("init_done_early", 64'(o_app_phy_init_done), 64'd0);
                chk("rdy_in_init", 64'(o_app_rdy), 64'd0);
                chk("wdf_rdy_in_init", 64'(o_app_wdf_rdy), 64'd0);
            end
            if (k == INIT) begin
                chk("init_done", 64'(o_app_phy_init_done), 64'd1);
                chk("rdy_after_init", 64'(o_app_rdy), 64'd1);
                chk("wdf_rdy_after_init", 64'(o_app_wdf_rdy), 64'd1);
            end
        end
    endtask

    // ---------------------------------------------------------- stimulus
    initial begin : main
        int          k;
        bit          written [8];
        logic [31:0] d0, d1;
        logic [MAD-1:0] a;
        int          op, slot;

        rst = 1'b1; i_stall = 1'b0; i_app_en = 1'b0; i_app_cmd = 3'b000;
        i_app_addr = '0; i_app_wdf_wren = 1'b0; i_app_wdf_end = 1'b0;
        i_app_wdf_data = '0;
        for (int i = 0; i < 8; i++) written[i] = 1'b0;

        // Reset state
        repeat (3) @(negedge ui_clk);
        chk("rst_init_done", 64'(o_app_phy_init_done), 64'd0);
        chk("rst_rdy", 64'(o_app_rdy), 64'd0);
        chk("rst_wdf_rdy", 64'(o_app_wdf_rdy), 64'd0);
        chk("rst_valid", 64'(o_app_rd_data_valid), 64'd0);
        chk("rst_data", 64'(o_app_rd_data), 64'd0);
        chk("rst_fault", 64'(o_fault), 64'd0);
        init_seq();

        // Basic write then read, with latency measured from acceptance:
        // one cycle to reach the queue head, RD_LATENCY to beat0, and the
        // first sampling negedge follows the accepting edge.
        write_burst(28'h8, 32'hA5A5_0001, 32'hA5A5_0002, 1'b1);
        repeat (5) @(negedge ui_clk);
        send_cmd(CMD_RD, 28'h8);
        k = 0;
        do begin
            @(negedge ui_clk); k++;
        end while (o_app_rd_data_valid !== 1'b1 && k < 60);
        chk("rd_latency", 64'(k), 64'(LAT + 2));
        drain();
        chk("fault_basic", 64'(o_fault), 64'(exp_fault));

        // Four beats ahead of two write commands
        for (int i = 0; i < 4; i++) send_beat(1'(i % 2), $urandom);
        send_cmd(CMD_WR, 28'h10);
        send_cmd(CMD_WR, 28'h18);
        send_cmd(CMD_RD, 28'h10);
        send_cmd(CMD_RD, 28'h18);
        drain();
        chk("fault_data_first", 64'(o_fault), 64'(exp_fault));

        // Command queue fills with data-less writes, then stall
        for (int i = 0; i < 8; i++) send_cmd(CMD_WR, 28'(28'h100 + 8 * i));
        @(negedge ui_clk); #1;
        chk("cmd_full_rdy", 64'(o_app_rdy), 64'd0);
        chk("cmd_full_wdf_rdy", 64'(o_app_wdf_rdy), 64'd1);
        i_stall = 1'b1;
        repeat (20) begin
            @(negedge ui_clk);
            chk("stall_rdy", 64'(o_app_rdy), 64'd0);
            chk("stall_wdf_rdy", 64'(o_app_wdf_rdy), 64'd0);
        end
        i_stall = 1'b0;
        for (int i = 0; i < 16; i++) send_beat(1'(i % 2), $urandom);
        write_burst(28'h140, $urandom, $urandom, 1'b0);
        write_burst(28'h148, $urandom, $urandom, 1'b1);
        for (int i = 0; i < 10; i++) send_cmd(CMD_RD, 28'(28'h100 + 8 * i));
        drain();

        // Randomised traffic over a small aliased burst pool
        for (int n = 0; n < 60; n++) begin
            op   = int'($urandom_range(0, 2));
            slot = int'($urandom_range(0, 7));
            a    = 28'(($urandom_range(0, 32767) << 13) | ((32 + slot) << 3));
            if (op == 2 && written[slot]) begin
                send_cmd(CMD_RD, a);
            end else begin
                d0 = $urandom; d1 = $urandom;
                write_burst(a, d0, d1, (op == 0));
                written[slot] = 1'b1;
            end
        end
        drain();
        chk("fault_random", 64'(o_fault), 64'(exp_fault));

        // Illegal command sets a sticky fault
        send_cmd(3'b010, 28'h0);
        chk("fault_illegal", 64'(o_fault), 64'(exp_fault));
        repeat (10) @(negedge ui_clk);
        chk("fault_sticky", 64'(o_fault), 64'd1);

        // Reset during the first read beat
        send_cmd(CMD_RD, 28'h8);
        k = 0;
        do begin
            @(negedge ui_clk); k++;
        end while (o_app_rd_data_valid !== 1'b1 && k < 60);
        chk("beat0_seen", 64'(o_app_rd_data_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(o_app_rd_data_valid), 64'd0);
        chk("rst_mid_init_done", 64'(o_app_phy_init_done), 64'd0);
        chk("rst_mid_fault", 64'(o_fault), 64'd0);
        expq.delete(); mcmd.delete(); mdata.delete();
        exp_fault = 1'b0; exp_end = 1'b0;
        repeat (3) @(negedge ui_clk);
        chk("rst_mid_no_beat1", 64'(o_app_rd_data_valid), 64'd0);
        init_seq();
        send_cmd(CMD_RD, 28'h8);
        send_cmd(CMD_RD, 28'h10);
        drain();

        // Framing: a clean burst, then end=1 twice in a row
        send_beat(1'b0, $urandom);
        send_beat(1'b1, $urandom);
        chk("fault_framing_ok", 64'(o_fault), 64'(exp_fault));
        send_beat(1'b1, $urandom);
        send_beat(1'b1, $urandom);
        chk("fault_framing", 64'(o_fault), 64'(exp_fault));
        repeat (10) @(negedge ui_clk);
        chk("fault_framing_sticky", 64'(o_fault), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
